// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: state codes and handshake levels.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider answering the EX-stage div/divu handshake.
// Returns {remainder, quotient}; signed operation works on magnitudes and
// corrects the signs on the final step.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Magnitude of an operand when dividing signed, raw value otherwise.
  function automatic logic [WIDTH-1:0] abs_val(input logic is_signed,
                                               input logic [WIDTH-1:0] x);
    if (is_signed && x[WIDTH-1]) return (~x) + WIDTH'(1);
    return x;
  endfunction

  // Two's complement negation applied only when the result sign requires it.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg,
                                              input logic [WIDTH-1:0] x);
    if (neg) return (~x) + WIDTH'(1);
    return x;
  endfunction

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quot_q;     // dividend bits shift out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] divisor_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The extra compare bit keeps the shifted remainder from overflowing; the
  // borrow out of bit WIDTH says the divisor did not fit.
  always_comb begin
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
    rem_step  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    quot_step = {quot_q[WIDTH-2:0], 1'b0};
    if (!rem_diff[WIDTH]) begin
      rem_step  = rem_diff[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end
  end

  // Handshake FSM with registered outputs; steps the divider while in ON.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_FREE;
      cnt        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              quot_q     <= abs_val(signed_div_i, opdata1_i);
              divisor_q  <= abs_val(signed_div_i, opdata2_i);
              rem_q      <= '0;
              cnt        <= '0;
              neg_quot_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_q  <= signed_div_i & opdata1_i[WIDTH-1];
              state      <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
          state    <= DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            cnt      <= '0;
            state    <= DIV_FREE;
          end else begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
            cnt    <= cnt + CNT_ONE;
            if (cnt == LAST_STEP) begin
              result_o <= {neg_if(neg_rem_q, rem_step), neg_if(neg_quot_q, quot_step)};
              ready_o  <= DIV_RESULT_READY;
              cnt      <= '0;
              state    <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP || annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            state    <= DIV_FREE;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          state    <= DIV_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases, handshake
// scenarios and randomized operations against a plain-arithmetic model.
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic [2*W-1:0] result;
  logic           ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // Reference: language division on 64-bit integers (truncating, remainder
  // takes the dividend's sign), truncated back to W bits.
  function automatic logic [2*W-1:0] ref_div(input logic sd, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint na, nb, q, r;
    if (b == '0) return '0;
    if (sd) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'b0, a});
      nb = longint'({32'b0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Raise start with operands and wait (bounded) for ready; lat=0 on timeout.
  task automatic do_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output int lat);
    @(negedge clk);
    signed_div = sd;
    op1 = a;
    op2 = b;
    start = 1'b1;
    lat = 0;
    res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready);
    else pass_cnt++;
    total_cnt++;
    if (result !== '0) $display("FAIL reset_result got %h want 0", result);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic           sd   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0]   ta   [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [W-1:0]   tb   [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [2*W-1:0] texp [6] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                 {32'd1, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                                 {32'd0, 32'hFFFF_FFFF}, 64'd0};
    int             tlat [6] = '{33, 33, 33, 33, 33, 2};
    logic [2*W-1:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(sd[i], ta[i], tb[i], res, lat);
      total_cnt++;
      if (lat !== tlat[i]) $display("FAIL directed%0d_latency got %0d want %0d", i, lat, tlat[i]);
      else pass_cnt++;
      total_cnt++;
      if (res !== texp[i]) $display("FAIL directed%0d_result got %h want %h", i, res, texp[i]);
      else pass_cnt++;
      drop_start();
      total_cnt++;
      if (ready !== 1'b0 || result !== '0)
        $display("FAIL directed%0d_release got ready=%b result=%h want 0/0", i, ready, result);
      else pass_cnt++;
    end
  endtask

  task automatic test_end_hold();
    logic [2*W-1:0] res;
    int lat;
    do_op(1'b0, 32'd1000, 32'd33, res, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (ready !== 1'b1 || result !== {32'd10, 32'd30})
        $display("FAIL end_hold%0d got ready=%b result=%h want 1/%h", k, ready, result, {32'd10, 32'd30});
      else pass_cnt++;
    end
    drop_start();
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL end_hold_release got %b want 0", ready);
    else pass_cnt++;
  endtask

  task automatic test_annul();
    logic [2*W-1:0] res;
    int lat;
    int seen;
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL annul_no_ready got %0d ready cycles want 0", seen);
    else pass_cnt++;
    do_op(1'b0, 32'd100, 32'd7, res, lat);
    total_cnt++;
    if (lat !== 33) $display("FAIL annul_restart_latency got %0d want 33", lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== {32'd2, 32'd14}) $display("FAIL annul_restart_result got %h want %h", res, {32'd2, 32'd14});
    else pass_cnt++;
    drop_start();
  endtask

  task automatic test_start_annul_same_cycle();
    int seen;
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd50;
    op2 = 32'd3;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL start_annul_same got %0d ready cycles want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_op();
    int seen;
    @(negedge clk);
    signed_div = 1'b1;
    op1 = 32'hFFFF_FF00;
    op2 = 32'd9;
    start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== '0)
      $display("FAIL rst_mid_op got ready=%b result=%h want 0/0", ready, result);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_mid_op_idle got %0d ready cycles want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_operand_change();
    logic [2*W-1:0] exp;
    int lat;
    exp = ref_div(1'b1, 32'hFFFF_F000, 32'd37);
    @(negedge clk);
    signed_div = 1'b1;
    op1 = 32'hFFFF_F000;
    op2 = 32'd37;
    start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op1 = 32'd12345;
    op2 = 32'd0;
    signed_div = 1'b0;
    lat = 0;
    for (int k = 6; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    total_cnt++;
    if (lat !== 33) $display("FAIL opchange_latency got %0d want 33", lat);
    else pass_cnt++;
    total_cnt++;
    if (result !== exp) $display("FAIL opchange_result got %h want %h", result, exp);
    else pass_cnt++;
    drop_start();
  endtask

  task automatic test_random();
    logic           sd;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] res, exp;
    int lat, want_lat;
    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      exp = ref_div(sd, a, b);
      want_lat = (b == '0) ? 2 : 33;
      do_op(sd, a, b, res, lat);
      total_cnt++;
      if (lat !== want_lat) $display("FAIL random%0d_latency got %0d want %0d", i, lat, want_lat);
      else pass_cnt++;
      total_cnt++;
      if (res !== exp)
        $display("FAIL random%0d_result sd=%b a=%h b=%h got %h want %h", i, sd, a, b, res, exp);
      else pass_cnt++;
      drop_start();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_end_hold();
    test_annul();
    test_start_annul_same_cycle();
    test_rst_mid_op();
    test_operand_change();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
